// File: rtl/display_pkg.sv
// Shared display-path definitions: link sequencer state width and encodings,
// also used by debug/status readers.
package display_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE        = 3'd0,
        ST_SERDES_RST  = 3'd1,
        ST_SERDES_WAKE = 3'd2,
        ST_BLANK       = 3'd3,
        ST_RUN         = 3'd4
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for quasi-static status bits crossing into the local
// clock domain.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= '0;
            o_q  <= '0;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/display_link_ctrl.sv
// TMDS link bring-up sequencer: waits for stable clock lock, pulses serializer
// reset, blanks for a few frames, then gates video; restarts on lock loss.
module display_link_ctrl
    import display_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_TICKS = 1024,
    parameter int unsigned RST_HOLD_TICKS    = 8,
    parameter int unsigned WAKE_TICKS        = 8,
    parameter int unsigned BLANK_FRAMES      = 2,
    parameter int unsigned CNT_W             = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clk_lock,
    input  logic               i_restart,
    input  logic               i_frame_start,
    output logic               o_rst_serdes,
    output logic               o_video_en,
    output logic               o_link_up,
    output logic [STATE_W-1:0] o_state,
    output logic [CNT_W-1:0]   o_relock_cnt
);

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_TICKS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST =
        (BLANK_FRAMES == 0) ? '0 : CNT_W'(BLANK_FRAMES - 1);

    logic             rst_meta_n;
    logic             rst_sync_n;
    logic             lock_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] relock_q, relock_d;
    logic             active;
    logic             rst_serdes_c;
    logic             video_c;

    // Async assert, synchronised release; holds everything (incl. serdes reset) while releasing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_meta_n <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_sync_n <= rst_meta_n;
        end
    end

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .i_clk   (i_clk),
        .i_rst_n (rst_sync_n),
        .i_d     (i_clk_lock),
        .o_q     (lock_s)
    );

    // State, counters and next-state-decoded outputs
    always_ff @(posedge i_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            frame_q      <= '0;
            relock_q     <= '0;
            o_rst_serdes <= 1'b1;
            o_video_en   <= 1'b0;
            o_link_up    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            frame_q      <= frame_d;
            relock_q     <= relock_d;
            o_rst_serdes <= rst_serdes_c;
            o_video_en   <= video_c;
            o_link_up    <= video_c;
        end
    end

    // Next-state and counter update; aborts override the per-state progression
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        frame_d  = frame_q;
        relock_d = relock_q;
        active   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_restart || !lock_s) begin
                    tick_d = '0;
                end else if (tick_q == LOCK_LAST) begin
                    state_d = ST_SERDES_RST;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
            ST_SERDES_RST: begin
                active = 1'b1;
                if (tick_q == RST_LAST) begin
                    state_d = ST_SERDES_WAKE;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
            ST_SERDES_WAKE: begin
                active = 1'b1;
                if (tick_q == WAKE_LAST) begin
                    tick_d  = '0;
                    frame_d = '0;
                    state_d = (BLANK_FRAMES == 0) ? ST_RUN : ST_BLANK;
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
            ST_BLANK: begin
                active = 1'b1;
                if (i_frame_start) begin
                    if (frame_q == FRAME_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        frame_d = frame_q + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                active = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
            end
        endcase

        if (active && (!lock_s || i_restart)) begin
            state_d = ST_IDLE;
            tick_d  = '0;
            if (!lock_s && (relock_q != '1)) begin
                relock_d = relock_q + CNT_W'(1);
            end
        end
    end

    // Output decode from the next state so registered outputs align with o_state
    always_comb begin
        rst_serdes_c = 1'b0;
        video_c      = 1'b0;
        unique case (state_d)
            ST_IDLE, ST_SERDES_RST: rst_serdes_c = 1'b1;
            ST_RUN:                 video_c      = 1'b1;
            default:                rst_serdes_c = 1'b0;
        endcase
    end

    assign o_state      = state_q;
    assign o_relock_cnt = relock_q;

endmodule

// File: tb/tb_display_link_ctrl.sv
// Directed bench for display_link_ctrl: a main instance with two blanking
// frames and a second instance with blanking skipped, sharing all inputs.
module tb_display_link_ctrl;

    typedef struct {
        logic       lock;
        logic       restart;
        logic       frame;
        int         n;
        logic [2:0] st;
        logic       rs;
        logic       vd;
        logic       lk;
        logic [7:0] rc;
        logic [2:0] zs;
        logic       zv;
    } vec_t;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_clk_lock = 1'b0;
    logic       i_restart = 1'b0;
    logic       i_frame_start = 1'b0;
    logic       o_rst_serdes, o_video_en, o_link_up;
    logic [2:0] o_state;
    logic [7:0] o_relock_cnt;
    logic       z_rst_serdes, z_video_en, z_link_up;
    logic [2:0] z_state;
    logic [7:0] z_relock_cnt;

    int checks = 0;
    int errors = 0;
    int exp_rc = 0;
    vec_t vecs[12];

    always #5 i_clk = ~i_clk;

    display_link_ctrl #(
        .LOCK_STABLE_TICKS(16), .RST_HOLD_TICKS(8), .WAKE_TICKS(4),
        .BLANK_FRAMES(2), .CNT_W(8)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clk_lock(i_clk_lock),
        .i_restart(i_restart), .i_frame_start(i_frame_start),
        .o_rst_serdes(o_rst_serdes), .o_video_en(o_video_en),
        .o_link_up(o_link_up), .o_state(o_state), .o_relock_cnt(o_relock_cnt)
    );

    display_link_ctrl #(
        .LOCK_STABLE_TICKS(16), .RST_HOLD_TICKS(8), .WAKE_TICKS(4),
        .BLANK_FRAMES(0), .CNT_W(8)
    ) dut_nob (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clk_lock(i_clk_lock),
        .i_restart(i_restart), .i_frame_start(i_frame_start),
        .o_rst_serdes(z_rst_serdes), .o_video_en(z_video_en),
        .o_link_up(z_link_up), .o_state(z_state), .o_relock_cnt(z_relock_cnt)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_state(input int tgt, input int budget, input string nm);
        int n;
        n = 0;
        while (int'(o_state) != tgt && n < budget) begin
            step();
            n++;
        end
        chk(nm, int'(o_state), tgt);
    endtask

    task automatic pulse_frame();
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        step();
    endtask

    function automatic vec_t mk(input int l, input int r, input int f, input int n,
                                input int st, input int rs, input int vd, input int lk,
                                input int rc, input int zs, input int zv);
        vec_t v;
        v.lock = 1'(l);  v.restart = 1'(r); v.frame = 1'(f); v.n = n;
        v.st = 3'(st);   v.rs = 1'(rs);     v.vd = 1'(vd);   v.lk = 1'(lk);
        v.rc = 8'(rc);   v.zs = 3'(zs);     v.zv = 1'(zv);
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, early, spur;

        // lock, restart, frame, cycles | state, rst, vid, link, relock | nob state, nob vid
        vecs[0]  = mk(1, 0, 0, 25,  1, 1, 0, 0, 0,  1, 0);
        vecs[1]  = mk(1, 0, 0, 1,   2, 0, 0, 0, 0,  2, 0);
        vecs[2]  = mk(1, 0, 0, 3,   2, 0, 0, 0, 0,  2, 0);
        vecs[3]  = mk(1, 0, 0, 1,   3, 0, 0, 0, 0,  4, 1);
        vecs[4]  = mk(1, 0, 0, 5,   3, 0, 0, 0, 0,  4, 1);
        vecs[5]  = mk(1, 0, 1, 1,   3, 0, 0, 0, 0,  4, 1);
        vecs[6]  = mk(1, 0, 0, 10,  3, 0, 0, 0, 0,  4, 1);
        vecs[7]  = mk(1, 0, 1, 1,   4, 0, 1, 1, 0,  4, 1);
        vecs[8]  = mk(1, 0, 0, 5,   4, 0, 1, 1, 0,  4, 1);
        vecs[9]  = mk(0, 0, 0, 2,   4, 0, 1, 1, 0,  4, 1);
        vecs[10] = mk(0, 0, 0, 1,   0, 1, 0, 0, 1,  0, 0);
        vecs[11] = mk(0, 0, 0, 5,   0, 1, 0, 0, 1,  0, 0);

        // Reset values
        step();
        step();
        chk("reset rst_serdes", int'(o_rst_serdes), 1);
        chk("reset video_en", int'(o_video_en), 0);
        chk("reset link_up", int'(o_link_up), 0);
        chk("reset state", int'(o_state), 0);
        chk("reset relock", int'(o_relock_cnt), 0);
        chk("reset nob rst_serdes", int'(z_rst_serdes), 1);
        i_rst_n = 1'b1;
        repeat (5) step();

        // Cold start, blanking, run, lock loss
        foreach (vecs[i]) begin
            i_clk_lock    = vecs[i].lock;
            i_restart     = vecs[i].restart;
            i_frame_start = vecs[i].frame;
            repeat (vecs[i].n) step();
            chk($sformatf("v%0d state", i), int'(o_state), int'(vecs[i].st));
            chk($sformatf("v%0d rst_serdes", i), int'(o_rst_serdes), int'(vecs[i].rs));
            chk($sformatf("v%0d video_en", i), int'(o_video_en), int'(vecs[i].vd));
            chk($sformatf("v%0d link_up", i), int'(o_link_up), int'(vecs[i].lk));
            chk($sformatf("v%0d relock", i), int'(o_relock_cnt), int'(vecs[i].rc));
            chk($sformatf("v%0d nob state", i), int'(z_state), int'(vecs[i].zs));
            chk($sformatf("v%0d nob video_en", i), int'(z_video_en), int'(vecs[i].zv));
            chk($sformatf("v%0d nob link_up", i), int'(z_link_up), int'(vecs[i].zv));
        end
        i_frame_start = 1'b0;
        exp_rc = 1;

        // Glitchy lock: one low cycle after 10 high restarts the stability count
        i_clk_lock = 1'b1;
        n = 0;
        repeat (10) begin step(); n++; end
        i_clk_lock = 1'b0;
        step(); n++;
        i_clk_lock = 1'b1;
        while (o_rst_serdes && n < 80) begin step(); n++; end
        chk("glitch rst_serdes fall cycle", n, 37);
        chk("glitch relock", int'(o_relock_cnt), exp_rc);

        // Restart in SERDES_WAKE: back to IDLE without counting a relock
        chk("wake state", int'(o_state), 2);
        i_restart = 1'b1;
        step();
        i_restart = 1'b0;
        chk("restart state", int'(o_state), 0);
        chk("restart rst_serdes", int'(o_rst_serdes), 1);
        chk("restart relock", int'(o_relock_cnt), exp_rc);

        // Restart in IDLE clears the stability count
        repeat (5) step();
        i_restart = 1'b1;
        step();
        n = 1;
        i_restart = 1'b0;
        while (o_rst_serdes && n < 80) begin step(); n++; end
        chk("idle restart rst_serdes fall cycle", n, 25);

        // Restart and lock loss in the same cycle: exactly one increment
        i_clk_lock = 1'b0;
        step();
        step();
        chk("pre-dual state", int'(o_state), 2);
        i_restart = 1'b1;
        step();
        i_restart = 1'b0;
        exp_rc++;
        chk("dual state", int'(o_state), 0);
        chk("dual relock", int'(o_relock_cnt), exp_rc);
        repeat (3) step();
        chk("dual relock settled", int'(o_relock_cnt), exp_rc);

        // Repeated lock loss in RUN until the counter saturates
        for (int it = 0; it < 260; it++) begin
            i_clk_lock = 1'b1;
            wait_state(3, 80, $sformatf("sat%0d blank", it));
            pulse_frame();
            pulse_frame();
            chk($sformatf("sat%0d run", it), int'(o_video_en), 1);
            i_clk_lock = 1'b0;
            repeat (3) step();
            exp_rc = (exp_rc < 255) ? exp_rc + 1 : 255;
            chk($sformatf("sat%0d state", it), int'(o_state), 0);
            chk($sformatf("sat%0d rst_serdes", it), int'(o_rst_serdes), 1);
            chk($sformatf("sat%0d video_en", it), int'(o_video_en), 0);
            chk($sformatf("sat%0d relock", it), int'(o_relock_cnt), exp_rc);
        end
        chk("saturated relock", int'(o_relock_cnt), 255);

        // Asynchronous reset in RUN, then clean restart
        i_clk_lock = 1'b1;
        wait_state(3, 80, "prereset blank");
        pulse_frame();
        pulse_frame();
        chk("prereset state", int'(o_state), 4);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async rst_serdes", int'(o_rst_serdes), 1);
        chk("async video_en", int'(o_video_en), 0);
        chk("async link_up", int'(o_link_up), 0);
        chk("async state", int'(o_state), 0);
        chk("async relock", int'(o_relock_cnt), 0);
        chk("async nob relock", int'(z_relock_cnt), 0);
        step();
        step();
        i_rst_n = 1'b1;
        early = 0;
        spur = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (k < 20 && !o_rst_serdes) early++;
            if (o_video_en || o_link_up) spur++;
        end
        chk("post-reset early rst_serdes drops", early, 0);
        chk("post-reset spurious video", spur, 0);
        chk("post-reset state", int'(o_state), 3);
        chk("post-reset relock", int'(o_relock_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
